// File: rtl/const_enc_pkg.sv
// rtl/const_enc_pkg.sv - shared constants and types for the constant nibble encoder
package const_enc_pkg;

    localparam int NIB_W    = 4;
    localparam int DATA_W   = 16;
    localparam int MAX_NIBS = DATA_W / NIB_W;

    typedef logic [2:0] count_t;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

endpackage

// File: rtl/nib_count.sv
// rtl/nib_count.sv - minimal signed-nibble count needed to represent a constant
module nib_count #(
    parameter int DATA_W = const_enc_pkg::DATA_W,
    parameter int NIB_W  = const_enc_pkg::NIB_W
) (
    input  logic [DATA_W-1:0]     data,
    output const_enc_pkg::count_t count
);
    import const_enc_pkg::*;

    localparam int NIBS = DATA_W / NIB_W;

    logic signed [DATA_W-1:0] shifted;

    // Walk widths from widest to narrowest so the smallest fitting width wins;
    // a width fits when every bit from its sign position upward is a copy of the sign.
    always_comb begin
        count   = count_t'(NIBS);
        shifted = '0;
        for (int k = NIBS; k >= 1; k--) begin
            shifted = $signed(data) >>> (NIB_W * k - 1);
            if ((shifted == '0) || (&shifted)) begin
                count = count_t'(k);
            end
        end
    end

endmodule

// File: rtl/const_nibble_encoder.sv
// rtl/const_nibble_encoder.sv - streams a signed constant as its minimal MSB-first nibble sequence
module const_nibble_encoder #(
    parameter int DATA_W = const_enc_pkg::DATA_W,
    parameter int NIB_W  = const_enc_pkg::NIB_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [NIB_W-1:0]  out_nib,
    output logic              out_first,
    output logic              out_last,
    output logic [2:0]        out_count
);
    import const_enc_pkg::*;

    localparam int NIBS = DATA_W / NIB_W;

    state_t            state;
    logic [DATA_W-1:0] sr;
    count_t            remaining;
    count_t            count;
    count_t            n_calc;

    nib_count #(
        .DATA_W (DATA_W),
        .NIB_W  (NIB_W)
    ) u_nib_count (
        .data  (in_data),
        .count (n_calc)
    );

    // Burst FSM: latch the constant and its nibble count, then count nibbles down on each handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sr        <= '0;
            remaining <= '0;
            count     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sr        <= in_data;
                        remaining <= n_calc;
                        count     <= n_calc;
                        state     <= EMIT;
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        // Dropping to zero on the last beat keeps out_nib at 0 while idle.
                        remaining <= remaining - count_t'(1);
                        if (remaining == count_t'(1)) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Select the nibble at index remaining-1; a zero count selects nothing.
    always_comb begin
        out_nib = '0;
        for (int i = 0; i < NIBS; i++) begin
            if (remaining == count_t'(i + 1)) begin
                out_nib = sr[i*NIB_W +: NIB_W];
            end
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == EMIT);
    assign out_first = (state == EMIT) && (remaining == count);
    assign out_last  = (state == EMIT) && (remaining == count_t'(1));
    assign out_count = count;

endmodule

// File: tb/tb_const_nibble_encoder.sv
// tb/tb_const_nibble_encoder.sv - self-checking bench for const_nibble_encoder
module tb_const_nibble_encoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [3:0]  out_nib;
    logic        out_first;
    logic        out_last;
    logic [2:0]  out_count;

    int checks = 0;
    int errors = 0;

    const_nibble_encoder #(.DATA_W(16), .NIB_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_nib   (out_nib),
        .out_first (out_first),
        .out_last  (out_last),
        .out_count (out_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Smallest k whose 4k-bit two's-complement range holds the value.
    function automatic int ref_n(input logic [15:0] d);
        int v;
        v = int'($signed(d));
        for (int k = 1; k <= 4; k++) begin
            if (v >= -(1 <<< (4*k-1)) && v <= (1 <<< (4*k-1)) - 1) return k;
        end
        return 0;
    endfunction

    // Reference model state
    logic [3:0]  q[$];
    logic [3:0]  seen[$];
    int          cur_n = 0;
    logic [15:0] orig = '0;
    bit          armed = 0;
    bit          rst_state = 0;
    int          acc = 0;
    int          beats = 0;

    // Compare DUT against the model, then advance the model by what the coming edge does.
    always @(negedge clk) begin
        if (armed) begin
            chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
            chk("in_ready", 32'(in_ready), 32'(q.size() == 0));
            if (q.size() > 0) begin
                chk("out_nib", 32'(out_nib), 32'(q[0]));
                chk("out_first", 32'(out_first), 32'(q.size() == cur_n));
                chk("out_last", 32'(out_last), 32'(q.size() == 1));
                chk("out_count", 32'(out_count), 32'(cur_n));
            end
            if (rst_state) begin
                chk("rst_out_nib", 32'(out_nib), 32'h0);
                chk("rst_out_count", 32'(out_count), 32'h0);
                chk("rst_out_first", 32'(out_first), 32'h0);
                chk("rst_out_last", 32'(out_last), 32'h0);
            end
        end
        if (rst) begin
            q.delete();
            cur_n = 0;
            rst_state = 1;
            armed = 1;
        end else if (armed) begin
            if (q.size() > 0 && out_ready) begin
                seen.push_back(out_nib);
                if (q.size() == cur_n) acc = {{28{out_nib[3]}}, out_nib};
                else acc = (acc <<< 4) | int'(out_nib);
                beats++;
                void'(q.pop_front());
                if (q.size() == 0) begin
                    chk("rebuild", 32'(acc), 32'(int'($signed(orig))));
                    chk("beat_count", 32'(beats), 32'(ref_n(orig)));
                end
            end else if (q.size() == 0 && in_valid) begin
                cur_n = ref_n(in_data);
                orig = in_data;
                for (int i = cur_n - 1; i >= 0; i--) q.push_back(4'((in_data >> (4*i)) & 16'hF));
                rst_state = 0;
                beats = 0;
            end
        end
    end

    task automatic send(input logic [15:0] v);
        bit got;
        got = 0;
        in_valid = 1'b1;
        in_data = v;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (in_ready) begin
                got = 1;
                break;
            end
        end
        if (!got) begin
            errors++;
            checks++;
            $display("FAIL send_timeout: data %0h never accepted", v);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit got;
        got = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (in_ready && q.size() == 0) begin
                got = 1;
                break;
            end
        end
        if (!got) begin
            errors++;
            checks++;
            $display("FAIL idle_timeout: encoder never returned idle");
        end
        @(posedge clk);
        #1;
    endtask

    // exp holds the expected nibbles MSB-first in its low 4n bits.
    task automatic check_seq(input string nm, input int n, input logic [31:0] exp);
        chk({nm, "_len"}, 32'(seen.size()), 32'(n));
        for (int i = 0; i < n && i < seen.size(); i++) begin
            chk({nm, "_nib"}, 32'(seen[i]), 32'(exp[4*(n-1-i) +: 4]));
        end
        seen.delete();
    endtask

    bit rnd_en = 0;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_en) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    logic [15:0] rv;

    initial begin
        chk("ref_n_0003", 32'(ref_n(16'h0003)), 32'd1);
        chk("ref_n_FFFC", 32'(ref_n(16'hFFFC)), 32'd1);
        chk("ref_n_0008", 32'(ref_n(16'h0008)), 32'd2);
        chk("ref_n_FF80", 32'(ref_n(16'hFF80)), 32'd2);
        chk("ref_n_00F0", 32'(ref_n(16'h00F0)), 32'd3);
        chk("ref_n_8000", 32'(ref_n(16'h8000)), 32'd4);

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_in_ready", 32'(in_ready), 32'h1);
        chk("reset_out_valid", 32'(out_valid), 32'h0);
        chk("reset_out_count", 32'(out_count), 32'h0);
        chk("reset_out_nib", 32'(out_nib), 32'h0);

        send(16'h0003);
        chk("t1_valid", 32'(out_valid), 32'h1);
        chk("t1_nib", 32'(out_nib), 32'h3);
        chk("t1_first", 32'(out_first), 32'h1);
        chk("t1_last", 32'(out_last), 32'h1);
        chk("t1_count", 32'(out_count), 32'h1);
        wait_idle();
        check_seq("s0003", 1, 32'h3);

        send(16'hFFFC); wait_idle(); check_seq("sFFFC", 1, 32'hC);
        send(16'h0007); wait_idle(); check_seq("s0007", 1, 32'h7);
        send(16'h0000); wait_idle(); check_seq("s0000", 1, 32'h0);
        send(16'h0008); wait_idle(); check_seq("s0008", 2, 32'h08);
        send(16'hFF80); wait_idle(); check_seq("sFF80", 2, 32'h80);
        send(16'h00F0); wait_idle(); check_seq("s00F0", 3, 32'h0F0);
        send(16'h1234); wait_idle(); check_seq("s1234", 4, 32'h1234);
        send(16'h8000); wait_idle(); check_seq("s8000", 4, 32'h8000);

        // Backpressure: out_ready pattern starts in the first nibble cycle.
        begin
            logic [6:0] pat;
            pat = 7'b1001011;
            send(16'h1234);
            for (int i = 6; i >= 0; i--) begin
                out_ready = pat[i];
                @(posedge clk);
                #1;
            end
            out_ready = 1'b1;
            chk("bp_in_ready_back", 32'(in_ready), 32'h1);
            wait_idle();
            check_seq("bp1234", 4, 32'h1234);
        end

        // A constant held on the input during a burst is taken only once idle.
        send(16'h1234);
        in_valid = 1'b1;
        in_data = 16'h5555;
        send(16'h5555);
        wait_idle();
        check_seq("busy_ignore", 8, 32'h12345555);

        // Reset in the cycle after the second nibble.
        send(16'h1234);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_out_valid", 32'(out_valid), 32'h0);
        chk("midrst_in_ready", 32'(in_ready), 32'h1);
        check_seq("midrst_partial", 2, 32'h12);
        send(16'h0003); wait_idle(); check_seq("after_rst", 1, 32'h3);

        rnd_en = 1;
        for (int i = 0; i < 2000; i++) begin
            rv = 16'($urandom);
            rv = 16'($signed(rv) >>> $urandom_range(0, 15));
            send(rv);
        end
        rnd_en = 0;
        wait_idle();
        out_ready = 1'b1;
        seen.delete();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
